// File: rtl/event_onehot_decoder_pkg.sv
// Shared constants for the event one-hot decoder slice.
package event_onehot_decoder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/lsb_prio_enc.sv
// LSB-priority encoder: isolates the lowest set request bit and reports its index.
module lsb_prio_enc
    import event_onehot_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned ID_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] onehot,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    always_comb begin
        onehot = req & (~req + WIDTH'(1));
        valid  = |req;
        idx    = '0;
        // Descending scan so the lowest set bit is the last (winning) assignment.
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (req[i]) idx = ID_W'(i);
        end
    end

endmodule

// File: rtl/rr_onehot_select.sv
// Round-robin pick: lowest request at or above ptr, else lowest request overall.
module rr_onehot_select
    import event_onehot_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned ID_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [WIDTH-1:0] onehot,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] hi_onehot, lo_onehot;
    logic [ID_W-1:0]  hi_idx, lo_idx;
    logic             hi_valid, lo_valid;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            mask[i] = (i >= 32'(ptr));
        end
    end

    lsb_prio_enc #(.WIDTH(WIDTH)) u_enc_hi (
        .req    (req & mask),
        .onehot (hi_onehot),
        .idx    (hi_idx),
        .valid  (hi_valid)
    );

    lsb_prio_enc #(.WIDTH(WIDTH)) u_enc_lo (
        .req    (req),
        .onehot (lo_onehot),
        .idx    (lo_idx),
        .valid  (lo_valid)
    );

    assign onehot = hi_valid ? hi_onehot : lo_onehot;
    assign idx    = hi_valid ? hi_idx : lo_idx;
    assign valid  = lo_valid;

endmodule

// File: rtl/event_onehot_decoder.sv
// Decodes event IDs into a sticky pending mask and drains it round-robin, one event per
// cycle, through a single output register with valid/ready handshake.
module event_onehot_decoder
    import event_onehot_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned ID_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_valid,
    input  logic [ID_W-1:0]  set_id,
    input  logic             clr_valid,
    input  logic [ID_W-1:0]  clr_id,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_onehot,
    output logic [ID_W-1:0]  out_id,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pending,
    output logic             dup_set
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] out_onehot_q, out_onehot_d;
    logic [ID_W-1:0]  out_id_q, out_id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             dup_q, dup_d;

    logic [WIDTH-1:0] set_dec, clr_dec, sel_onehot;
    logic [ID_W-1:0]  sel_id;
    logic             sel_valid, load;

    // Out-of-range IDs decode to nothing.
    always_comb begin
        set_dec = '0;
        clr_dec = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            set_dec[i] = set_valid && (32'(set_id) == i);
            clr_dec[i] = clr_valid && (32'(clr_id) == i);
        end
    end

    rr_onehot_select #(.WIDTH(WIDTH)) u_select (
        .req    (pending_q),
        .ptr    (rr_ptr_q),
        .onehot (sel_onehot),
        .idx    (sel_id),
        .valid  (sel_valid)
    );

    always_comb begin
        state_d      = state_q;
        out_onehot_d = out_onehot_q;
        out_id_d     = out_id_q;
        load         = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (sel_valid) begin
                    load    = 1'b1;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (out_ready) begin
                    if (sel_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d      = StEmpty;
                        out_onehot_d = '0;
                        out_id_d     = '0;
                    end
                end
            end
            default: state_d = StEmpty;
        endcase
        if (load) begin
            out_onehot_d = sel_onehot;
            out_id_d     = sel_id;
        end
    end

    // Clear before set so set wins; the entry moving to the output leaves the mask.
    assign pending_d = ((pending_q & ~clr_dec) | set_dec) & ~(load ? sel_onehot : '0);
    assign dup_d     = |(set_dec & pending_q & ~clr_dec);
    assign rr_ptr_d  = !load ? rr_ptr_q
                     : (32'(sel_id) == WIDTH - 1) ? '0 : sel_id + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StEmpty;
            pending_q    <= '0;
            out_onehot_q <= '0;
            out_id_q     <= '0;
            rr_ptr_q     <= '0;
            dup_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            out_onehot_q <= out_onehot_d;
            out_id_q     <= out_id_d;
            rr_ptr_q     <= rr_ptr_d;
            dup_q        <= dup_d;
        end
    end

    assign out_valid  = (state_q == StFull);
    assign out_onehot = out_onehot_q;
    assign out_id     = out_id_q;
    assign pending    = pending_q;
    assign dup_set    = dup_q;

endmodule

// File: tb/tb_event_onehot_decoder.sv
// Bench for event_onehot_decoder: directed scenarios plus random traffic against an
// array-based reference model.
module tb_event_onehot_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       set_valid, clr_valid, out_ready;
    logic [2:0] set_id, clr_id;
    logic       out_valid, dup_set;
    logic [7:0] out_onehot, pending;
    logic [2:0] out_id;

    int checks = 0;
    int errors = 0;

    // Reference state: pending flags per ID, held event, round-robin start, dup flag.
    int m_pend[8];
    int m_hv, m_hid, m_rr, m_dup;

    always #5 clk = ~clk;

    event_onehot_decoder #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .set_valid  (set_valid),
        .set_id     (set_id),
        .clr_valid  (clr_valid),
        .clr_id     (clr_id),
        .out_valid  (out_valid),
        .out_onehot (out_onehot),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .pending    (pending),
        .dup_set    (dup_set)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_pend[i] = 0;
        m_hv = 0; m_hid = 0; m_rr = 0; m_dup = 0;
    endtask

    task automatic check_model(input string tag);
        int pm;
        pm = 0;
        for (int i = 0; i < 8; i++) if (m_pend[i] != 0) pm += (1 << i);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_hv));
        chk({tag, ".out_onehot"}, 32'(out_onehot), m_hv != 0 ? 32'(1 << m_hid) : 32'd0);
        chk({tag, ".out_id"}, 32'(out_id), m_hv != 0 ? 32'(m_hid) : 32'd0);
        chk({tag, ".pending"}, 32'(pending), 32'(pm));
        chk({tag, ".dup_set"}, 32'(dup_set), 32'(m_dup));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare after it.
    task automatic step(input string tag, input int sv, input int sid, input int cv,
                        input int cid, input int rdy);
        int nxt[8];
        int k;
        set_valid = sv[0]; set_id = 3'(sid);
        clr_valid = cv[0]; clr_id = 3'(cid);
        out_ready = rdy[0];
        m_dup = (sv != 0 && m_pend[sid] != 0 && !(cv != 0 && cid == sid)) ? 1 : 0;
        for (int i = 0; i < 8; i++)
            nxt[i] = ((m_pend[i] != 0 && !(cv != 0 && cid == i)) || (sv != 0 && sid == i))
                     ? 1 : 0;
        k = -1;
        if (m_hv == 0 || rdy != 0) begin
            for (int j = 0; j < 8; j++) begin
                if (k < 0 && m_pend[(m_rr + j) % 8] != 0) k = (m_rr + j) % 8;
            end
        end
        if (k >= 0) begin
            nxt[k] = 0; m_hv = 1; m_hid = k; m_rr = (k + 1) % 8;
        end else if (m_hv != 0 && rdy != 0) begin
            m_hv = 0;
        end
        m_pend = nxt;
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        model_reset();
        reset = 1'b1; set_valid = 1'b1; set_id = 3'd2;
        clr_valid = 1'b0; clr_id = 3'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.out_onehot", 32'(out_onehot), 0);
        chk("rst.out_id", 32'(out_id), 0);
        chk("rst.pending", 32'(pending), 0);
        chk("rst.dup_set", 32'(dup_set), 0);
        set_valid = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step("idle", 0, 0, 0, 0, 1);

        // Single event, delivered two cycles after the set.
        step("single.c1", 1, 3, 0, 0, 1);
        step("single.c2", 0, 0, 0, 0, 1);
        chk("single.onehot", 32'(out_onehot), 32'h08);
        chk("single.id", 32'(out_id), 3);
        step("single.c3", 0, 0, 0, 0, 1);
        chk("single.drained", 32'(out_valid), 0);

        // Round-robin under backpressure: hold 5, queue 2 and 6.
        step("rr.set5", 1, 5, 0, 0, 0);
        step("rr.load5", 0, 0, 0, 0, 0);
        step("rr.set2", 1, 2, 0, 0, 0);
        step("rr.set6", 1, 6, 0, 0, 0);
        chk("rr.pending44", 32'(pending), 32'h44);
        chk("rr.hold5", 32'(out_id), 5);
        step("rr.stall", 0, 0, 0, 0, 0);
        step("rr.grant6", 0, 0, 0, 0, 1);
        chk("rr.id6", 32'(out_id), 6);
        step("rr.grant2", 0, 0, 0, 0, 1);
        chk("rr.id2", 32'(out_id), 2);
        step("rr.empty", 0, 0, 0, 0, 1);

        // Same-ID set/clear: set wins.
        step("col.set0", 1, 0, 0, 0, 0);
        step("col.load0", 0, 0, 0, 0, 0);
        step("col.setclr4", 1, 4, 1, 4, 0);
        chk("col.pending10", 32'(pending), 32'h10);

        // Duplicate set merges into one pending bit.
        step("dup.set1", 1, 1, 0, 0, 0);
        step("dup.set1again", 1, 1, 0, 0, 0);
        chk("dup.pulse", 32'(dup_set), 1);
        step("dup.after", 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("dup.drain", 0, 0, 0, 0, 1);

        // Clearing the held event leaves the output untouched.
        step("hold.set7", 1, 7, 0, 0, 0);
        step("hold.load7", 0, 0, 0, 0, 0);
        step("hold.clr7", 0, 0, 1, 7, 0);
        chk("hold.id7", 32'(out_id), 7);
        for (int i = 0; i < 4; i++) step("hold.fill", 1, i, 0, 0, 0);
        chk("hold.pending0f", 32'(pending), 32'h0F);

        // Asynchronous reset mid-burst.
        set_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mrst.out_valid", 32'(out_valid), 0);
        chk("mrst.out_onehot", 32'(out_onehot), 0);
        chk("mrst.out_id", 32'(out_id), 0);
        chk("mrst.pending", 32'(pending), 0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) step("mrst.after", 0, 0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
